muldiv_hilo: RTL and testbench
==============================

MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width; legal range 4..64.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request to execute op this cycle.
REQ-005 SHALL have port op, input, 3: operation code (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
REQ-006 SHALL have port a, input, WIDTH: operand A (dividend / multiplicand / MTHI-MTLO data).
REQ-007 SHALL have port b, input, WIDTH: operand B (divisor / multiplier).
REQ-008 SHALL have port rd_req, input, 1: downstream wants to read HI or LO this cycle.
REQ-009 SHALL have port cancel, input, 1: pipeline flush; abort the in-flight operation.
REQ-010 SHALL have port busy, output, 1: iterative operation in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse; HI/LO hold the new result.
REQ-012 SHALL have port stall, output, 1: pipeline must hold the current instruction.
REQ-013 SHALL have port hi, output, WIDTH: HI register.
REQ-014 SHALL have port lo, output, WIDTH: LO register.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-016 SHALL accept start only in IDLE or DONE; a start in RUN is not accepted.
REQ-017 SHALL drive stall = busy & (start | rd_req), combinationally.
REQ-018 SHALL, on accepted MTHI/MTLO, write a into HI/LO at that edge; other register unchanged; no state change, no done pulse.
REQ-019 SHALL, on accepted MULT/MULTU/DIV/DIVU, latch magnitudes and signs of a and b, load the iteration counter with WIDTH, and enter RUN.
REQ-020 SHALL perform one shift-add (multiply) or one restoring-subtract (divide) step per RUN cycle; exactly WIDTH RUN cycles.
REQ-021 SHALL give fixed latency: start in cycle 0 gives busy in cycles 1..WIDTH and done plus new HI/LO in cycle WIDTH+1, independent of operand values.
REQ-022 SHALL, for multiply, produce a 2*WIDTH product with {HI,LO} = product; MULT is two's-complement signed, MULTU unsigned.
REQ-023 SHALL, for divide, set LO = quotient and HI = remainder; DIV truncates toward zero with remainder sign equal to dividend sign; DIVU is unsigned.
REQ-024 SHALL apply sign correction during the final RUN edge, with no extra cycle.
REQ-025 SHALL, on divide by zero (b=0), run the full latency and produce LO = all ones and HI = a, for both DIV and DIVU.
REQ-026 SHALL, for DIV with most-negative dividend / -1, produce LO = most-negative and HI = 0.
REQ-027 SHALL leave DONE for IDLE after one cycle, or for RUN if a start of a new mul/div is accepted in DONE.
REQ-028 SHALL, on cancel in RUN, go to IDLE at that edge with HI/LO unchanged and no done pulse; cancel in IDLE/DONE has no effect, and cancel has priority over a simultaneous start.
REQ-029 SHALL keep HI/LO stable except on an accepted MTHI/MTLO, at the final RUN edge, or on reset.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, set the FSM to IDLE, hi=0, lo=0, busy=0, done=0 and the counter to 0; this aborts any operation in progress, and rst overrides start and cancel.

Structure
REQ-031 SHALL take the op encodings (MULT=3'b001, MULTU=3'b010, DIV=3'b011, DIVU=3'b100, MTHI=3'b101, MTLO=3'b110; others are no-op) and the FSM state enum from shared package muldiv_pkg.
REQ-032 SHALL derive counter width as clog2(WIDTH+1) locally.
REQ-033 SHALL place the HI/LO registers with write enables in one sub-module hilo_reg; the iterative datapath stays in muldiv_hilo.

Verification (WIDTH=32 unless stated)
REQ-034 SHALL check: MULT a=-3, b=7 -> done in cycle 33, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB; MULTU a=b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=1.
REQ-035 SHALL check: DIV a=-7, b=2 -> lo=-3, hi=-1; DIVU a=7, b=0 -> lo=32'hFFFF_FFFF, hi=7; DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
REQ-036 SHALL check: start MULT, then rd_req in cycles 1..32 -> stall=1 throughout; stall=0 in cycle 33; a second start at cycle 33 is accepted, with done at cycle 66.
REQ-037 SHALL check: cancel in cycle 10 of a DIV -> busy=0 from cycle 11, no done, hi/lo keep their prior values (MTHI 5, MTLO 9 beforehand -> 5, 9).
REQ-038 SHALL check: rst in cycle 20 of a MULT -> hi=lo=0, busy=0, no done afterward; same bench at WIDTH=8 checks MULT -128*-128 = {hi=8'h40, lo=8'h00} at cycle 9.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op encodings and controller state type for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// HI/LO architectural registers with independent write enables.
module hilo_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_d,
  input  logic [WIDTH-1:0] lo_d,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit writing HI/LO, fixed latency of WIDTH+1 cycles.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no operation; start accepted
// ST_RUN  | one shift-add / restoring-subtract step per cycle, busy=1
// ST_DONE | one-cycle done pulse; HI/LO hold the result; start accepted
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e state, state_next;

  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   acc, mq, opnd;
  logic               is_div, neg_q, neg_r, div_zero;

  logic               accept, go_run, last;
  logic               sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   acc_step, mq_step;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic               hi_we, lo_we;
  logic [WIDTH-1:0]   hi_d, lo_d;

  always_comb begin
    accept = start && (state != ST_RUN);
    go_run = accept && is_muldiv(op);
    last   = (state == ST_RUN) && (count == CW'(1));
    sa     = is_signed_op(op) && a[WIDTH-1];
    sb     = is_signed_op(op) && b[WIDTH-1];
    a_mag  = sa ? -a : a;
    b_mag  = sb ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: if (go_run) state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (cancel)    state_next = ST_IDLE;
        else if (last) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = go_run ? ST_RUN : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign stall = busy & (start | rd_req);

  // One iteration: multiply shifts {acc,mq} right after adding, divide shifts left then trial-subtracts.
  always_comb begin
    mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, mq[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    acc_step  = mul_sum[WIDTH:1];
    mq_step   = {mul_sum[0], mq[WIDTH-1:1]};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        acc_step = div_diff[WIDTH-1:0];
        mq_step  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = div_shift[WIDTH-1:0];
        mq_step  = {mq[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction is folded into the final step so the result lands on the last RUN edge.
  always_comb begin
    prod_mag = {acc_step, mq_step};
    prod_fix = neg_q ? -prod_mag : prod_mag;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_d     = a;
    lo_d     = a;
    if (last && !cancel) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      if (is_div) begin
        hi_d = neg_r ? -acc_step : acc_step;
        lo_d = div_zero ? '1 : (neg_q ? -mq_step : mq_step);
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end else if (accept && (op == OP_MTHI)) begin
      hi_we = 1'b1;
    end else if (accept && (op == OP_MTLO)) begin
      lo_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (go_run) begin
      count    <= CW'(WIDTH);
      acc      <= '0;
      is_div   <= (op == OP_DIV) || (op == OP_DIVU);
      neg_q    <= sa ^ sb;
      neg_r    <= sa;
      div_zero <= (b == '0);
      if ((op == OP_DIV) || (op == OP_DIVU)) begin
        mq   <= a_mag;
        opnd <= b_mag;
      end else begin
        mq   <= b_mag;
        opnd <= a_mag;
      end
    end else if (state == ST_RUN) begin
      count <= cancel ? '0 : count - CW'(1);
      acc   <= acc_step;
      mq    <= mq_step;
    end
  end

  hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk   (clk),
    .rst   (rst),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .hi_d  (hi_d),
    .lo_d  (lo_d),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: directed corner cases plus random ops against an arithmetic reference.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, rd_req, cancel;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo;

  logic         start8;
  logic [2:0]   op8;
  logic [7:0]   a8, b8;
  logic         busy8, done8, stall8;
  logic [7:0]   hi8, lo8;

  int           total = 0;
  int           fails = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .rd_req(rd_req), .cancel(cancel), .busy(busy), .done(done),
    .stall(stall), .hi(hi), .lo(lo)
  );

  muldiv_hilo #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .rd_req(1'b0), .cancel(1'b0), .busy(busy8), .done(done8),
    .stall(stall8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {HI,LO} from plain arithmetic on the architectural operands.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint     sp;
    logic [63:0] up;
    int         sq, sr;
    case (o)
      OP_MULT: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return sp;
      end
      OP_MULTU: begin
        up = {32'b0, x} * {32'b0, y};
        return up;
      end
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      OP_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  // Issues a mul/div in the current cycle and returns positioned in its done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit hold_rd, input bit noise);
    logic [63:0] exp;
    exp    = ref_model(o, x, y);
    start  = 1'b1;
    op     = o;
    a      = x;
    b      = y;
    rd_req = 1'b0;
    cancel = 1'b0;
    #1;
    check("stall_issue", stall, 1'b0);
    tick();
    for (int c = 1; c <= W; c++) begin
      start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      op     = 3'($urandom);
      a      = $urandom;
      b      = $urandom;
      rd_req = hold_rd ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      #1;
      check("run_busy", busy, 1'b1);
      check("run_done", done, 1'b0);
      check("run_stall", stall, start | rd_req);
      check("run_hilo", {hi, lo}, {m_hi, m_lo});
      tick();
    end
    start  = 1'b0;
    rd_req = 1'b0;
    m_hi   = exp[63:32];
    m_lo   = exp[31:0];
    #1;
    check("fin_done", done, 1'b1);
    check("fin_busy", busy, 1'b0);
    check("fin_hi", hi, m_hi);
    check("fin_lo", lo, m_lo);
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] x);
    start = 1'b1;
    op    = o;
    a     = x;
    tick();
    start = 1'b0;
    if (o == OP_MTHI) m_hi = x;
    else              m_lo = x;
    #1;
    check("mt_done", done, 1'b0);
    check("mt_busy", busy, 1'b0);
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  initial begin
    logic [2:0]  ops [6];
    logic [2:0]  o;
    logic [31:0] x, y;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

    rst = 1'b1; start = 1'b0; rd_req = 1'b0; cancel = 1'b0;
    op = OP_NOP; a = '0; b = '0;
    start8 = 1'b0; op8 = OP_NOP; a8 = '0; b8 = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_hilo8", {hi8, lo8}, 16'h0);
    tick();

    // WIDTH=8: -128 * -128
    start8 = 1'b1; op8 = OP_MULT; a8 = 8'h80; b8 = 8'h80;
    tick();
    start8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check("w8_busy", busy8, 1'b1);
      check("w8_nodone", done8, 1'b0);
      tick();
    end
    check("w8_done", done8, 1'b1);
    check("w8_hi", hi8, 8'h40);
    check("w8_lo", lo8, 8'h00);
    tick();

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    tick();
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h1);
    tick();
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    tick();
    run_op(OP_DIVU, 32'd7, 32'd0, 1'b0, 1'b0);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd7);
    tick();
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0);
    tick();

    // rd_req held through RUN, then back-to-back start from DONE
    run_op(OP_MULT, 32'd12345, 32'hFFFF_0001, 1'b1, 1'b0);
    rd_req = 1'b1;
    #1;
    check("stall_in_done", stall, 1'b0);
    run_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    tick();

    // cancel mid-DIV keeps prior HI/LO
    mt(OP_MTHI, 32'd5);
    mt(OP_MTLO, 32'd9);
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    cancel = 1'b1;
    #1;
    check("cancel_c10_busy", busy, 1'b1);
    tick();
    cancel = 1'b0;
    check("cancel_c11_busy", busy, 1'b0);
    for (int c = 0; c < 40; c++) begin
      check("cancel_nodone", done, 1'b0);
      check("cancel_hilo", {hi, lo}, {32'd5, 32'd9});
      tick();
    end

    // reset mid-MULT
    mt(OP_MTHI, 32'h1234);
    start = 1'b1; op = OP_MULT; a = 32'd77; b = 32'd99;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("rstrun_hi", hi, 32'h0);
    check("rstrun_lo", lo, 32'h0);
    check("rstrun_busy", busy, 1'b0);
    for (int c = 0; c < 20; c++) begin
      check("rstrun_nodone", done, 1'b0);
      check("rstrun_nobusy", busy, 1'b0);
      tick();
    end

    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 5)];
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       y = 32'h0;
        1:       y = 32'hFFFF_FFFF;
        2:       y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      if (o == OP_MTHI || o == OP_MTLO) mt(o, x);
      else                              run_op(o, x, y, 1'b0, 1'b1);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
